// File: rtl/primecheck_pkg.sv
// Shared types and constants for the primality checker.
package primecheck_pkg;

   localparam int DEFAULT_WIDTH_LOG = 4;

   // Controller states, 3-bit encoding.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ERROR     = 3'd1,
      S_CHECK     = 3'd2,
      S_DIV_START = 3'd3,
      S_DIV_WAIT  = 3'd4
   } state_t;

   // Half the data width; trial divisors never exceed 2^HI + 1.
   function automatic int half_width(input int width_log);
      return (1 << width_log) / 2;
   endfunction

endpackage

// File: rtl/primecheck_divrem.sv
// Sequential restoring divider: one quotient bit per cycle, W cycles per
// division. ready drops the cycle after an accepted go; a zero divisor is
// rejected immediately with error=1 and ready left high.
module primecheck_divrem #(
   parameter int WIDTH_LOG = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       go,
   input  logic [(1<<WIDTH_LOG)-1:0]  num,
   input  logic [(1<<WIDTH_LOG)-1:0]  den,
   output logic                       ready,
   output logic                       error,
   output logic [(1<<WIDTH_LOG)-1:0]  quo,
   output logic [(1<<WIDTH_LOG)-1:0]  rem
);

   localparam int W = 1 << WIDTH_LOG;

   logic [W-1:0]         rem_r;
   logic [W-1:0]         quo_r;
   logic [W-1:0]         den_r;
   logic [WIDTH_LOG-1:0] count;
   logic [W:0]           shifted;

   // Partial remainder with the next dividend bit shifted in.
   always_comb begin
      shifted = {rem_r, quo_r[W-1]};
   end

   // Accept a division when idle, then iterate until the bit counter hits zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b1;
         error <= 1'b0;
         rem_r <= '0;
         quo_r <= '0;
         den_r <= '0;
         count <= '0;
      end else if (ready) begin
         if (go) begin
            if (den == '0) begin
               error <= 1'b1;
            end else begin
               error <= 1'b0;
               ready <= 1'b0;
               quo_r <= num;
               rem_r <= '0;
               den_r <= den;
               count <= WIDTH_LOG'(W - 1);
            end
         end
      end else begin
         if (shifted >= {1'b0, den_r}) begin
            rem_r <= W'(shifted - {1'b0, den_r});
            quo_r <= {quo_r[W-2:0], 1'b1};
         end else begin
            rem_r <= shifted[W-1:0];
            quo_r <= {quo_r[W-2:0], 1'b0};
         end
         if (count == '0) begin
            ready <= 1'b1;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   assign quo = quo_r;
   assign rem = rem_r;

endmodule

// File: rtl/primecheck.sv
// Primality checker by trial division (2, then odd divisors) through divrem.
// Reports the smallest factor >1 for composites, num for primes, 0 for num<2.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | result valid, waiting for go
// S_ERROR     | last check aborted by divider error, waiting for go
// S_CHECK     | decide: done (n<2 or div^2>n) or start a trial division
// S_DIV_START | divrem registers its operands and drops ready
// S_DIV_WAIT  | wait for divrem, then finish on rem==0 or advance div
module primecheck
   import primecheck_pkg::*;
#(
   parameter int WIDTH_LOG = DEFAULT_WIDTH_LOG
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       go,
   input  logic [(1<<WIDTH_LOG)-1:0]  num,
   output logic                       ready,
   output logic                       error,
   output logic                       is_prime,
   output logic [(1<<WIDTH_LOG)-1:0]  factor
);

   localparam int W  = 1 << WIDTH_LOG;
   localparam int HI = half_width(WIDTH_LOG);
   localparam int W2 = 2 * W;

   state_t       state;
   logic [W-1:0] n;
   logic [W-1:0] div;
   logic [W:0]   div_sq;
   logic         div_go;
   logic         div_ready;
   logic         div_error;
   logic [W-1:0] quo;
   logic [W-1:0] rem;

   primecheck_divrem #(.WIDTH_LOG(WIDTH_LOG)) u_divrem (
      .clk   (clk),
      .rst   (rst),
      .go    (div_go),
      .num   (n),
      .den   (div),
      .ready (div_ready),
      .error (div_error),
      .quo   (quo),
      .rem   (rem)
   );

   // Controller FSM; ready/error are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ready    <= 1'b1;
         error    <= 1'b0;
         is_prime <= 1'b0;
         factor   <= '0;
         div_go   <= 1'b0;
         n        <= '0;
         div      <= '0;
         div_sq   <= '0;
      end else begin
         div_go <= 1'b0;
         case (state)
            S_IDLE, S_ERROR: begin
               if (go) begin
                  n      <= num;
                  div    <= W'(2);
                  div_sq <= (W+1)'(4);
                  state  <= S_CHECK;
                  ready  <= 1'b0;
                  error  <= 1'b0;
               end
            end
            S_CHECK: begin
               if (n < W'(2)) begin
                  state    <= S_IDLE;
                  ready    <= 1'b1;
                  is_prime <= 1'b0;
                  factor   <= '0;
               end else if (div_sq > {1'b0, n}) begin
                  state    <= S_IDLE;
                  ready    <= 1'b1;
                  is_prime <= 1'b1;
                  factor   <= n;
               end else begin
                  div_go <= 1'b1;
                  state  <= S_DIV_START;
               end
            end
            S_DIV_START: begin
               state <= S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
               if (div_error) begin
                  state    <= S_ERROR;
                  ready    <= 1'b1;
                  error    <= 1'b1;
                  is_prime <= 1'b0;
                  factor   <= '0;
               end else if (div_ready) begin
                  if (rem == '0) begin
                     state    <= S_IDLE;
                     ready    <= 1'b1;
                     is_prime <= 1'b0;
                     factor   <= div;
                  end else begin
                     state <= S_CHECK;
                     if (div == W'(2)) begin
                        div    <= W'(3);
                        div_sq <= (W+1)'(9);
                     end else begin
                        div    <= div + W'(2);
                        div_sq <= div_sq + ({1'b0, div} << 2) + (W+1)'(4);
                     end
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               error <= 1'b0;
            end
         endcase
      end
   end

   // Invariants: div_sq tracks div^2, div stays in range, divrem results are consistent.
   always_ff @(posedge clk) begin
      if (!rst && state == S_CHECK) begin
         assert (W2'(div) * W2'(div) == W2'(div_sq));
         assert (div >= W'(2) && W2'(div) <= W2'((1 << HI) + 1));
      end
      if (!rst && state == S_DIV_WAIT && div_ready && !div_error) begin
         assert (W2'(quo) * W2'(div) + W2'(rem) == W2'(n));
         assert (rem < div);
      end
   end

endmodule

// File: doc/primecheck.md
Name: primecheck

Overview:
- Inverse companion to the prime generator: instead of producing the next prime, it accepts an arbitrary candidate and decides whether it is prime.
- Uses trial division through the existing divrem unit.
- On a composite input it reports the smallest non-trivial factor.
- Used by testbenches and by downstream logic to validate generator output; shares the same go/ready/error handshake style.

Parameters:
- WIDTH_LOG, 4, log2 of data width; W = 1 << WIDTH_LOG.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- go  in  1  start request; sampled only while ready=1
- num  in  W  candidate; latched on accepted go
- ready  out  1  idle/result valid (registered)
- error  out  1  last check aborted by divider error (registered)
- is_prime  out  1  result: candidate is prime
- factor  out  W  smallest divisor >1 if composite; num if prime; 0 if num<2

Behaviour:
- Reset (rst=1 at posedge) aborts any operation, including mid-division. State=IDLE, ready=1, error=0, is_prime=0, factor=0, div_go=0. divrem is reset by the same rst.
- Internal registers:
  - n (W bits): latched candidate.
  - div (W bits): current trial divisor.
  - div_sq (W+1 bits): exact square of div. The W+1 width means no overflow or clamping is needed; the maximum div tested is 2^(W/2)+1.
- States: IDLE, ERROR, CHECK, DIV_START, DIV_WAIT.
- IDLE/ERROR:
  - go=1 → n<=num, div<=2, div_sq<=4, go to CHECK.
  - go=0 → hold; outputs unchanged.
- CHECK:
  - n<2 → IDLE, is_prime<=0, factor<=0.
  - else div_sq>n → IDLE, is_prime<=1, factor<=n.
  - else → assert div_go for one cycle with den=div, go to DIV_START.
- DIV_START: single wait state so divrem registers its inputs and drops ready; → DIV_WAIT.
- DIV_WAIT:
  - div_error → ERROR, is_prime<=0, factor<=0.
  - !div_ready → stay.
  - rem==0 → IDLE, is_prime<=0, factor<=div.
  - otherwise advance the divisor and go to CHECK:
    - div==2 → div<=3, div_sq<=9.
    - else div<=div+2, div_sq<=div_sq+4*div+4.
- Output timing:
  - ready and error are registered from next_state: ready = next_state∈{IDLE, ERROR}; error = next_state==ERROR.
  - ready falls the cycle after go is accepted.
  - is_prime and factor update in the same cycle ready rises, and hold until the next completion.
- go while busy: ignored, not queued. num changes while busy: ignored (n is latched).
- Latency: 2 cycles for num<4. For larger num, 2 cycles plus, per divisor tried, (CHECK + DIV_START + divrem latency + DIV_WAIT). Worst case is about 2^(W/2-1) divisions.
- Divider error cannot occur in normal operation (div≥2). ERROR is a defensive path.
- ERROR is exited only by go or rst.

Decomposition:
- Shared defines header holds:
  - state localparams for IDLE/ERROR/CHECK/DIV_START/DIV_WAIT, 3-bit encoding;
  - the derived W/HI constants;
  - the assert macros, which are used for div_sq monotonicity and div advance.
- One sub-module: the existing divrem (WIDTH_LOG passed through, num=n, den=div).
- No RAM; the prime table is not consulted.

Test Plan:
- Reset, then num=0, go → ready low exactly 1 cycle; is_prime=0, factor=0, error=0.
- num=2, then num=3 → each prime, factor equals num, no div_go pulse observed; num=4 → is_prime=0, factor=2 after one division.
- num=9 → divisions by 2 (rem 1) then 3 (rem 0); is_prime=0, factor=3. num=25 → factor=5.
- num=65521 (W=16) → divisors 2,3,5,…,255 tried, stop at div_sq=66049; is_prime=1, factor=65521. num=65535 → factor=3.
- go pulsed and num changed while busy checking 97 → ignored; result is is_prime=1, factor=97.
- rst asserted during DIV_WAIT → next cycle ready=1, error=0, is_prime=0, factor=0; a subsequent check of num=15 returns factor=3.
- Cross-check: feed each prime output by the generator after reset (2,3,5,7,11,13,…) → every one reports is_prime=1.
